// File: rtl/mem_arbiter_if.sv
// Memory-side bus of mem_arbiter: one registered request with a single-cycle ack.
// Signals: mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o (arbiter drives); mem_rdata_i, mem_ack_i (memory drives).
interface mem_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic              mem_req_o;
   logic              mem_we_o;
   logic [ADDR_W-1:0] mem_addr_o;
   logic [DATA_W-1:0] mem_wdata_o;
   logic [DATA_W-1:0] mem_rdata_i;
   logic              mem_ack_i;

   modport master (
      output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
      input  mem_rdata_i, mem_ack_i
   );

   modport slave (
      input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
      output mem_rdata_i, mem_ack_i
   );
endinterface

// File: rtl/mem_arbiter.sv
// Shares one handshaked memory between IF and DM ports, DM first, with per-port served flags.
// Ports: clk_i, rst_i (sync, high); IF req/addr/data/stall; DM req/we/addr/wdata/rdata/stall;
// pipe_adv_i; mem (mem_arbiter_if.master); err_o only with MEM_ARB_TIMEOUT_EN defined.
module mem_arbiter #(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 64
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              if_req_i,
   input  logic [ADDR_W-1:0] if_addr_i,
   output logic [DATA_W-1:0] if_data_o,
   output logic              if_stall_o,
   input  logic              dm_req_i,
   input  logic              dm_we_i,
   input  logic [ADDR_W-1:0] dm_addr_i,
   input  logic [DATA_W-1:0] dm_wdata_i,
   output logic [DATA_W-1:0] dm_rdata_o,
   output logic              dm_stall_o,
   input  logic              pipe_adv_i,
`ifdef MEM_ARB_TIMEOUT_EN
   output logic              err_o,
`endif
   mem_arbiter_if.master     mem
);

   typedef enum logic [1:0] {
      IDLE,
      BUSY_DM,
      BUSY_IF
   } state_t;

   state_t            state;
   logic              if_valid;
   logic              dm_valid;
   logic              if_pend;
   logic              dm_pend;
   logic              req_q;
   logic              we_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;
   logic              expire;
   logic              done;
   logic [DATA_W-1:0] rsp_data;

   assign dm_pend    = dm_req_i & ~dm_valid;
   assign if_pend    = if_req_i & ~if_valid;
   assign dm_stall_o = dm_pend;
   assign if_stall_o = if_pend;

   assign mem.mem_req_o   = req_q;
   assign mem.mem_we_o    = we_q;
   assign mem.mem_addr_o  = addr_q;
   assign mem.mem_wdata_o = wdata_q;

`ifdef MEM_ARB_TIMEOUT_EN
   localparam int CNT_W = (TIMEOUT < 255) ? 8 : $clog2(TIMEOUT + 1);

   logic [CNT_W-1:0] cnt;

   // A real ack in the expiry cycle still wins over the abort.
   assign expire = ~mem.mem_ack_i & (cnt == CNT_W'(TIMEOUT - 1));
`else
   logic unused_timeout;

   assign unused_timeout = (TIMEOUT > 0);
   assign expire         = 1'b0;
`endif

   assign done     = (state != IDLE) & (mem.mem_ack_i | expire);
   assign rsp_data = expire ? DATA_W'(32'hDEADBEEF) : mem.mem_rdata_i;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state      <= IDLE;
         req_q      <= 1'b0;
         we_q       <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         if_data_o  <= '0;
         dm_rdata_o <= '0;
         if_valid   <= 1'b0;
         dm_valid   <= 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
         cnt        <= '0;
         err_o      <= 1'b0;
`endif
      end else begin
         // Advance retires the current instruction; its requests become new.
         if (pipe_adv_i) begin
            if_valid <= 1'b0;
            dm_valid <= 1'b0;
         end
`ifdef MEM_ARB_TIMEOUT_EN
         if (state == IDLE) cnt <= '0;
         else               cnt <= cnt + 1'b1;
         if (done && expire) err_o <= 1'b1;
`endif
         unique case (state)
            IDLE: begin
               if (dm_pend) begin
                  state   <= BUSY_DM;
                  req_q   <= 1'b1;
                  we_q    <= dm_we_i;
                  addr_q  <= dm_addr_i;
                  wdata_q <= dm_wdata_i;
               end else if (if_pend) begin
                  state   <= BUSY_IF;
                  req_q   <= 1'b1;
                  we_q    <= 1'b0;
                  addr_q  <= if_addr_i;
               end
            end
            BUSY_DM: begin
               if (done) begin
                  state <= IDLE;
                  req_q <= 1'b0;
                  if (!we_q || expire) dm_rdata_o <= rsp_data;
                  if (dm_req_i && !pipe_adv_i) dm_valid <= 1'b1;
               end
            end
            BUSY_IF: begin
               if (done) begin
                  state     <= IDLE;
                  req_q     <= 1'b0;
                  if_data_o <= rsp_data;
                  if (if_req_i && !pipe_adv_i) if_valid <= 1'b1;
               end
            end
            default: begin
               state <= IDLE;
               req_q <= 1'b0;
            end
         endcase
      end
   end

endmodule
